// File: rtl/prog_loader_if.sv
// Host, CPU and RAM signal bundle for the program loader.
// The master side feeds the host stream, the CPU bus and the RAM read data; the slave side is the loader.
interface prog_loader_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
);
  logic                     i_start;
  logic [ADDRESS_WIDTH:0]   i_length;
  logic [DATA_WIDTH-1:0]    i_checksum;
  logic                     i_valid;
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     o_ready;
  logic [ADDRESS_WIDTH-1:0] i_cpu_addr;
  logic [DATA_WIDTH-1:0]    i_cpu_data;
  logic                     i_cpu_we;
  logic [ADDRESS_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0]    o_ram_data;
  logic                     o_ram_we;
  logic [DATA_WIDTH-1:0]    i_ram_q;
  logic                     o_cpu_rst;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_error;

  modport master (
    output i_start, i_length, i_checksum, i_valid, i_data,
    output i_cpu_addr, i_cpu_data, i_cpu_we, i_ram_q,
    input  o_ready, o_ram_addr, o_ram_data, o_ram_we,
    input  o_cpu_rst, o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_length, i_checksum, i_valid, i_data,
    input  i_cpu_addr, i_cpu_data, i_cpu_we, i_ram_q,
    output o_ready, o_ram_addr, o_ram_data, o_ram_we,
    output o_cpu_rst, o_busy, o_done, o_error
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: writes a host image into RAM, verifies it by checksum on read-back,
// then releases the CPU from reset and hands it the RAM port.
module prog_loader #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 64
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERROR} state_t;

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_L = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  state_t                   state, next_state;
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr, rd_last;
  logic [ADDRESS_WIDTH:0]   length, xfer_cnt, ver_cnt;
  logic [DATA_WIDTH-1:0]    checksum, load_sum, ver_sum, ver_final;
  logic                     start_bad, xfer, load_last, ver_last;
  logic                     cpu_rst, busy, done, error, ready;

  function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  assign start_bad = (bus.i_length == '0) || (bus.i_length > DEPTH_L);
  assign xfer      = (state == LOAD) && bus.i_valid && ready;
  // The transfer count ends the load; wr_ptr alone wraps to 0 for a full-depth image.
  assign load_last = xfer && ((xfer_cnt + CNT_ONE) == length);
  assign ver_last  = (state == VERIFY) && (ver_cnt == length);
  assign ver_final = wrap_add(ver_sum, bus.i_ram_q);
  assign rd_last   = ADDRESS_WIDTH'(length - CNT_ONE);

  // State register and registered status decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cpu_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state   <= next_state;
      cpu_rst <= (next_state != RUN);
      busy    <= (next_state == LOAD) || (next_state == VERIFY);
      done    <= (next_state == RUN);
      error   <= (next_state == ERROR);
      ready   <= (next_state == LOAD);
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, RUN, ERROR: if (bus.i_start) next_state = start_bad ? ERROR : LOAD;
      LOAD:             if (load_last) next_state = VERIFY;
      VERIFY: begin
        if (ver_last)
          next_state = ((load_sum == checksum) && (ver_final == checksum)) ? RUN : ERROR;
      end
      default:          next_state = IDLE;
    endcase
  end

  // Pointers, counters and running sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      length   <= '0;
      xfer_cnt <= '0;
      ver_cnt  <= '0;
      checksum <= '0;
      load_sum <= '0;
      ver_sum  <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERROR: begin
          if (bus.i_start) begin
            length   <= bus.i_length;
            checksum <= bus.i_checksum;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            xfer_cnt <= '0;
            ver_cnt  <= '0;
            load_sum <= '0;
            ver_sum  <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            xfer_cnt <= xfer_cnt + CNT_ONE;
            load_sum <= wrap_add(load_sum, bus.i_data);
          end
          if (load_last) begin
            rd_ptr  <= '0;
            ver_cnt <= '0;
          end
        end
        VERIFY: begin
          // RAM read data lags the address by one cycle, so the first verify cycle adds nothing.
          if (ver_cnt != '0) ver_sum <= ver_final;
          if (rd_ptr != rd_last) rd_ptr <= rd_ptr + PTR_ONE;
          ver_cnt <= ver_cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // RAM port mux
  always_comb begin
    bus.o_ram_addr = '0;
    bus.o_ram_data = '0;
    bus.o_ram_we   = 1'b0;
    case (state)
      LOAD: begin
        bus.o_ram_addr = wr_ptr;
        bus.o_ram_data = bus.i_data;
        bus.o_ram_we   = xfer;
      end
      VERIFY: bus.o_ram_addr = rd_ptr;
      RUN: begin
        bus.o_ram_addr = bus.i_cpu_addr;
        bus.o_ram_data = bus.i_cpu_data;
        bus.o_ram_we   = bus.i_cpu_we;
      end
      default: ;
    endcase
  end

  assign bus.o_ready   = ready;
  assign bus.o_cpu_rst = cpu_rst;
  assign bus.o_busy    = busy;
  assign bus.o_done    = done;
  assign bus.o_error   = error;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: models blram, drives host images and keeps a write/result scoreboard.
module tb_prog_loader;
  localparam int AW    = 6;
  localparam int DW    = 10;
  localparam int DEPTH = 64;

  typedef struct {
    bit run;
    int lat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  prog_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // blram: synchronous write, registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_data;
    bus.i_ram_q <= mem[bus.o_ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int img [DEPTH];
  logic [AW+DW-1:0] wq [$];
  res_t rq [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and load outcomes as the DUT presents them
  int cyc = 0;
  int start_cyc = 0;
  bit prev_done = 1'b0;
  bit prev_err = 1'b0;
  logic [AW+DW-1:0] exp_w;
  res_t r;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (bus.i_start && !bus.o_busy) start_cyc = cyc;
      if (bus.o_ram_we && !bus.o_done) begin
        if (!bus.o_busy || wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_write: addr %0d data %0d written with no word pending", bus.o_ram_addr, bus.o_ram_data);
        end else begin
          exp_w = wq.pop_front();
          chk("write_addr", bus.o_ram_addr, exp_w[AW+DW-1:DW]);
          chk("write_data", bus.o_ram_data, exp_w[DW-1:0]);
        end
      end
      if ((bus.o_done && !prev_done) || (bus.o_error && !prev_err)) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: done=%0d error=%0d with no load outstanding", bus.o_done, bus.o_error);
        end else begin
          r = rq.pop_front();
          chk("result_done", bus.o_done, r.run);
          chk("result_error", bus.o_error, !r.run);
          chk("result_cpu_rst", bus.o_cpu_rst, !r.run);
          chk("result_latency", cyc - start_cyc, r.lat);
        end
      end
      prev_done = bus.o_done;
      prev_err  = bus.o_error;
    end
  end

  // Issues a load; gap<0 drops i_valid every third cycle, otherwise gap is a percent chance.
  task automatic do_load(input int len, input int cks, input int gap, input bit poke);
    int k = 0;
    int g = 0;
    int sum = 0;
    int i = 0;
    bit gap_now;
    @(posedge clk); #1;
    bus.i_start    = 1'b1;
    bus.i_length   = (AW+1)'(len);
    bus.i_checksum = DW'(cks);
    bus.i_valid    = 1'b1;
    bus.i_data     = DW'($urandom);
    if (len == 0 || len > DEPTH) begin
      rq.push_back('{run: 1'b0, lat: 1});
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      chk("illegal_error", bus.o_error, 1);
      return;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("start_cpu_rst", bus.o_cpu_rst, 1);
    chk("start_ready", bus.o_ready, 1);
    bus.i_cpu_we = 1'b1;
    while (k < len) begin
      gap_now = (gap < 0) ? (i % 3 == 2) : (int'($urandom_range(99)) < gap);
      if (gap_now) begin
        bus.i_valid = 1'b0;
        bus.i_data  = DW'($urandom);
        g++;
      end else begin
        bus.i_valid = 1'b1;
        bus.i_data  = DW'(img[k]);
        wq.push_back({AW'(k), DW'(img[k])});
        sum += img[k];
        k++;
      end
      bus.i_start = poke && (i == len / 2);
      if (bus.i_start) bus.i_length = (AW+1)'(1);
      bus.i_cpu_addr = AW'($urandom);
      bus.i_cpu_data = DW'($urandom);
      i++;
      @(posedge clk); #1;
    end
    bus.i_valid  = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_cpu_we = 1'b0;
    rq.push_back('{run: ((sum % 1024) == cks), lat: 2 * len + g + 2});
    if (poke) begin
      bus.i_start  = 1'b1;
      bus.i_length = (AW+1)'(1);
      @(posedge clk); #1;
      bus.i_start = 1'b0;
    end
  endtask

  task automatic wait_result(input int bound);
    int n = 0;
    while (!(bus.o_done || bus.o_error) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(bus.o_done || bus.o_error)) begin
      checks++;
      errors++;
      $display("FAIL wait_result: neither done nor error after %0d cycles", bound);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_ram(input int len);
    for (int k = 0; k < len; k++) chk($sformatf("ram[%0d]", k), mem[k], img[k]);
  endtask

  function automatic int fill_random(input int len);
    int s = 0;
    for (int k = 0; k < len; k++) begin
      img[k] = int'($urandom_range(1023));
      s += img[k];
    end
    return s % 1024;
  endfunction

  initial begin
    int len, sum, cks;
    bus.i_start = 0; bus.i_length = '0; bus.i_checksum = '0;
    bus.i_valid = 0; bus.i_data = '0;
    bus.i_cpu_addr = '0; bus.i_cpu_data = '0; bus.i_cpu_we = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cpu_rst", bus.o_cpu_rst, 1);
    chk("reset_ready", bus.o_ready, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_done", bus.o_done, 0);
    chk("reset_error", bus.o_error, 0);
    chk("reset_ram_we", bus.o_ram_we, 0);
    chk("reset_ram_addr", bus.o_ram_addr, 0);
    rst = 1'b0;

    // Basic three-word load, then CPU pass-through
    img[0] = 1; img[1] = 2; img[2] = 3;
    do_load(3, 6, 0, 1'b0);
    wait_result(100);
    check_ram(3);
    bus.i_cpu_addr = AW'(40); bus.i_cpu_data = DW'(10'h155); bus.i_cpu_we = 1'b1;
    #1;
    chk("pass_addr", bus.o_ram_addr, 40);
    chk("pass_data", bus.o_ram_data, 10'h155);
    chk("pass_we", bus.o_ram_we, 1);
    @(posedge clk); #1;
    bus.i_cpu_we = 1'b0;
    @(posedge clk); #1;
    chk("pass_read", bus.i_ram_q, 10'h155);

    // Full depth from RUN, backpressure, starts poked into LOAD and VERIFY
    for (int k = 0; k < DEPTH; k++) img[k] = k;
    do_load(64, 992, -1, 1'b1);
    wait_result(300);
    check_ram(64);
    chk("full_error", bus.o_error, 0);

    // Checksum mismatch, then recovery
    img[0] = 5; img[1] = 5;
    do_load(2, 11, 0, 1'b0);
    wait_result(50);
    chk("mismatch_cpu_rst", bus.o_cpu_rst, 1);
    sum = fill_random(7);
    do_load(7, sum, 20, 1'b0);
    wait_result(100);
    check_ram(7);

    // Illegal lengths
    do_load(65, 0, 0, 1'b0);
    wait_result(10);
    img[0] = 9;
    do_load(1, 9, 0, 1'b0);
    wait_result(20);
    do_load(0, 0, 0, 1'b0);
    wait_result(10);

    // Randomized images, half with a corrupted checksum
    repeat (6) begin
      len = int'($urandom_range(1, 64));
      sum = fill_random(len);
      cks = ($urandom_range(1) == 0) ? sum : (sum + int'($urandom_range(1, 1023))) % 1024;
      do_load(len, cks, int'($urandom_range(0, 40)), 1'($urandom_range(1)));
      wait_result(400);
      check_ram(len);
    end

    // Asynchronous reset after 10 of 20 words
    void'(fill_random(20));
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_length = (AW+1)'(20); bus.i_checksum = '0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = DW'(img[k]);
      wq.push_back({AW'(k), DW'(img[k])});
      @(posedge clk); #1;
    end
    bus.i_data = DW'(img[10]);
    #2 rst = 1'b1;
    #1;
    chk("rst_ram_we", bus.o_ram_we, 0);
    chk("rst_cpu_rst", bus.o_cpu_rst, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_ready", bus.o_ready, 0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    rst = 1'b0;
    chk("rst_pending_writes", wq.size(), 0);
    sum = fill_random(60);
    do_load(60, sum, 10, 1'b0);
    wait_result(300);
    check_ram(60);
    bus.i_cpu_addr = AW'(52); bus.i_cpu_we = 1'b0;
    @(posedge clk); #1;
    chk("cpu_read_word52", bus.i_ram_q, img[52]);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", rq.size(), 0);
    chk("pending_writes", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that sits between a host word stream, the FBCPU memory port and the `blram` RAM. After reset it holds the CPU in reset and owns the RAM port. It writes a host-supplied program image into consecutive RAM words from address 0, then reads the image back and checks it against a checksum. On success it releases the CPU and passes the CPU's RAM bus straight through to `blram`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 6: RAM address width.
- `DATA_WIDTH`, 10: RAM word width.
- `DEPTH`, 64: number of RAM words; equals 2^ADDRESS_WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle pulse that begins a load; samples `i_length` and `i_checksum`.
- `i_length`  in  ADDRESS_WIDTH+1  number of words to load; legal range is 1..DEPTH.
- `i_checksum`  in  DATA_WIDTH  expected sum of all words, mod 2^DATA_WIDTH.
- `i_valid`  in  1  host word valid.
- `i_data`  in  DATA_WIDTH  host word.
- `o_ready`  out  1  loader accepts `i_data`.
- `i_cpu_addr`  in  ADDRESS_WIDTH  CPU MAR.
- `i_cpu_data`  in  DATA_WIDTH  CPU MDRIn.
- `i_cpu_we`  in  1  CPU RAMWr.
- `o_ram_addr`  out  ADDRESS_WIDTH  to `blram` `i_addr`.
- `o_ram_data`  out  DATA_WIDTH  to `blram` `i_ram_data_in`.
- `o_ram_we`  out  1  to `blram` `i_we`.
- `i_ram_q`  in  DATA_WIDTH  from `blram` `o_ram_data_out`; valid one cycle after the address is presented.
- `o_cpu_rst`  out  1  drives FBCPU `rst`.
- `o_busy`  out  1  high in LOAD and VERIFY.
- `o_done`  out  1  high in RUN.
- `o_error`  out  1  high in ERROR.

## Operation
States: IDLE, LOAD, VERIFY, RUN, ERROR.

- **Reset:**
  - State goes to IDLE.
  - `o_cpu_rst`=1; `o_ready`, `o_busy`, `o_done`, `o_error`=0.
  - Address counter, length register and both sums are cleared.
- **IDLE:**
  - RAM port is driven with addr=0, data=0, we=0.
  - On `i_start`, latch length and checksum and clear counters.
  - If the length is 0 or greater than DEPTH, go to ERROR; otherwise go to LOAD.
- **LOAD:**
  - `o_ready`=1.
  - A transfer occurs in a cycle with `i_valid`=1 and `o_ready`=1.
  - On a transfer: `o_ram_we`=1, `o_ram_addr`=wr_ptr and `o_ram_data`=`i_data`, all combinational in that cycle. Then wr_ptr increments and load_sum += `i_data` (mod 2^DATA_WIDTH).
  - `i_valid`=0 idles without penalty; wr_ptr and load_sum hold.
  - After transfer number `length`, go to VERIFY with rd_ptr=0.
  - For length=DEPTH, wr_ptr wraps to 0 after the last word. The transfer count, not the pointer, ends the phase.
- **VERIFY:**
  - `o_ram_we`=0 and `o_ram_addr`=rd_ptr; rd_ptr increments each cycle until it reaches length−1.
  - `i_ram_q` is accumulated into ver_sum one cycle after each address is issued.
  - The phase lasts length+1 cycles.
  - At the end, if load_sum == checksum and ver_sum == checksum, go to RUN; otherwise go to ERROR.
- **RUN:**
  - `o_cpu_rst`=0 and `o_done`=1.
  - `o_ram_addr`/`o_ram_data`/`o_ram_we` mirror the CPU inputs combinationally.
- **ERROR:**
  - `o_error`=1 and `o_cpu_rst`=1.
  - RAM port is driven to idle (addr=0, data=0, we=0).
- **`i_start` handling:**
  - In RUN or ERROR, `i_start` starts a new load exactly as from IDLE, and `o_cpu_rst` reasserts on the next edge.
  - `i_start` is ignored in LOAD and VERIFY.
- **CPU inputs outside RUN:** `i_cpu_*` are ignored in every state except RUN; the CPU never writes RAM while it is held in reset.

## Timing
- `o_cpu_rst`, `o_busy`, `o_done`, `o_error` and `o_ready` are registered state decodes.
- RAM port outputs are combinational muxes selected by state.
- **Start to first write:** `i_start` at edge N puts the loader in LOAD after edge N, so the first write can occur in cycle N+1.
- **Minimum load time:** length cycles with `i_valid` held high.
- **VERIFY to RUN:** the state enters RUN on the edge after the last `i_ram_q` is sampled. `o_cpu_rst` falls with that same edge.
- **Total, start to CPU release:** 1 + length + (length+1) cycles minimum.
- **Asynchronous `rst` mid-LOAD or mid-VERIFY:**
  - Returns to IDLE immediately, `o_cpu_rst`=1, and `o_ram_we`=0 combinationally.
  - Words already written stay in RAM but are not trusted; a fresh load is required.
- **Simultaneous `i_start` and `i_valid` in IDLE:** the word is not accepted, because `o_ready` is 0.

## Test plan
- **Basic load:** `i_start`, length=3, checksum=0x006; stream words 1,2,3 back to back -> RAM[0..2]=1,2,3; RUN after 1+3+4 cycles; `o_cpu_rst` falls; CPU bus passes through.
- **Full depth with backpressure:** length=64, words 0..63 with `i_valid` low every third cycle, checksum=2016 mod 1024=992 -> RAM[k]=k, no extra writes, RUN, `o_error`=0.
- **Checksum mismatch:** length=2, words 5,5, checksum=11 -> ERROR; `o_cpu_rst` stays 1; a following `i_start` with a correct image reaches RUN.
- **Illegal length:** length=0, then length=65 -> each goes to ERROR on the edge after `i_start`; no RAM write occurs.
- **Reset mid-load:** assert `rst` after 10 of 20 words -> IDLE immediately, `o_we`=0, `o_cpu_rst`=1; a reload completes and the CPU program (memory check word 52) runs correctly.
- **Reload from RUN and ignored starts:** `i_start` in RUN -> `o_cpu_rst`=1 on the next edge; the new image loads. An `i_start` pulse inside LOAD and inside VERIFY is ignored, and the counters continue.
